// File: rtl/nvme_queue_ctrl_if.sv
// Front-end, CQE, doorbell AXI-Lite write and status signals of one NVMe queue pair.
// master = the queue controller, slave = front end / CQ source / doorbell target.
interface nvme_queue_ctrl_if #(
  parameter int OUTSTANDING   = 16,
  parameter int NL_ADDR_WIDTH = 32,
  parameter int NL_DATA_WIDTH = 32
);
  localparam int PW = $clog2(OUTSTANDING);

  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [PW-1:0]              alloc_slot;
  logic                       submit_valid;
  logic                       submit_ready;
  logic                       cqe_valid;
  logic [15:0]                cqe_cid;
  logic                       cqe_phase;
  logic [14:0]                cqe_status;
  logic                       cqe_ready;
  logic                       done_valid;
  logic [PW-1:0]              done_cid;
  logic [14:0]                done_status;
  logic                       done_ready;
  logic [NL_ADDR_WIDTH-1:0]   nl_awaddr;
  logic                       nl_awvalid;
  logic                       nl_awready;
  logic [NL_DATA_WIDTH-1:0]   nl_wdata;
  logic [NL_DATA_WIDTH/8-1:0] nl_wstrb;
  logic                       nl_wvalid;
  logic                       nl_wready;
  logic [1:0]                 nl_bresp;
  logic                       nl_bvalid;
  logic                       nl_bready;
  logic [PW:0]                inflight;
  logic                       err;

  modport master (
    input  alloc_valid, submit_valid, cqe_valid, cqe_cid, cqe_phase, cqe_status,
           done_ready, nl_awready, nl_wready, nl_bresp, nl_bvalid,
    output alloc_ready, alloc_slot, submit_ready, cqe_ready, done_valid, done_cid,
           done_status, nl_awaddr, nl_awvalid, nl_wdata, nl_wstrb, nl_wvalid,
           nl_bready, inflight, err
  );

  modport slave (
    output alloc_valid, submit_valid, cqe_valid, cqe_cid, cqe_phase, cqe_status,
           done_ready, nl_awready, nl_wready, nl_bresp, nl_bvalid,
    input  alloc_ready, alloc_slot, submit_ready, cqe_ready, done_valid, done_cid,
           done_status, nl_awaddr, nl_awvalid, nl_wdata, nl_wstrb, nl_wvalid,
           nl_bready, inflight, err
  );
endinterface

// File: rtl/nvme_queue_ctrl.sv
// NVMe SQ/CQ pair sequencer: slot alloc, submit count, phase-checked CQE to 1-deep done register,
// doorbells via AXI-Lite (>=3 cycles each); CQE stalls only while done is held, doorbells coalesce.
module nvme_queue_ctrl #(
  parameter int          OUTSTANDING   = 16,
  parameter int          NL_ADDR_WIDTH = 32,
  parameter int          NL_DATA_WIDTH = 32,
  parameter logic [31:0] SQ_DB_ADDR    = 32'h1008,
  parameter logic [31:0] CQ_DB_ADDR    = 32'h100C
) (
  input logic            clk,
  input logic            rst,
  nvme_queue_ctrl_if.master q
);
  localparam int PW = $clog2(OUTSTANDING);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [PW-1:0]            alloc_ptr, sub_ptr, cq_head;
  logic [PW:0]              inflight_q, unsub;
  logic                     exp_phase, sq_db_pend, cq_db_pend, err_q;
  logic                     done_vld_q;
  logic [PW-1:0]            done_cid_q;
  logic [14:0]              done_status_q;
  logic [1:0]               state;
  logic                     aw_vld, w_vld;
  logic [NL_ADDR_WIDTH-1:0] awaddr_q;
  logic [NL_DATA_WIDTH-1:0] wdata_q;

  logic alloc_hs, sub_hs, cqe_acc, cqe_ok, cqe_bad;
  logic aw_done, w_done, idle_take_cq, idle_take_sq, bad_resp;

  // unsub counts allocated-but-unsubmitted slots so a full unsubmitted ring is distinguishable
  assign q.alloc_ready  = ~rst & (inflight_q < (PW+1)'(OUTSTANDING));
  assign q.submit_ready = ~rst & (unsub != '0);
  assign q.cqe_ready    = ~rst & (~done_vld_q | q.done_ready);
  assign q.alloc_slot   = alloc_ptr;
  assign q.done_valid   = ~rst & done_vld_q;
  assign q.done_cid     = done_cid_q;
  assign q.done_status  = done_status_q;
  assign q.nl_awaddr    = awaddr_q;
  assign q.nl_awvalid   = ~rst & aw_vld;
  assign q.nl_wdata     = wdata_q;
  assign q.nl_wstrb     = '1;
  assign q.nl_wvalid    = ~rst & w_vld;
  assign q.nl_bready    = ~rst & (state == ST_RESP);
  assign q.inflight     = inflight_q;
  assign q.err          = ~rst & err_q;

  assign alloc_hs     = q.alloc_valid & q.alloc_ready;
  assign sub_hs       = q.submit_valid & q.submit_ready;
  assign cqe_acc      = q.cqe_valid & q.cqe_ready;
  assign cqe_ok       = cqe_acc & (q.cqe_phase == exp_phase) & (q.cqe_cid < 16'(OUTSTANDING));
  assign cqe_bad      = cqe_acc & ~cqe_ok;
  assign aw_done      = ~aw_vld | q.nl_awready;
  assign w_done       = ~w_vld | q.nl_wready;
  assign idle_take_cq = (state == ST_IDLE) & cq_db_pend;
  assign idle_take_sq = (state == ST_IDLE) & ~cq_db_pend & sq_db_pend;
  assign bad_resp     = (state == ST_RESP) & q.nl_bvalid & (q.nl_bresp != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr     <= '0;
      sub_ptr       <= '0;
      cq_head       <= '0;
      inflight_q    <= '0;
      unsub         <= '0;
      exp_phase     <= 1'b1;
      sq_db_pend    <= 1'b0;
      cq_db_pend    <= 1'b0;
      err_q         <= 1'b0;
      done_vld_q    <= 1'b0;
      done_cid_q    <= '0;
      done_status_q <= '0;
      state         <= ST_IDLE;
      aw_vld        <= 1'b0;
      w_vld         <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
    end else begin
      if (alloc_hs) alloc_ptr <= alloc_ptr + PW'(1);
      if (sub_hs)   sub_ptr   <= sub_ptr + PW'(1);

      case ({alloc_hs, cqe_ok})
        2'b10:   inflight_q <= inflight_q + (PW+1)'(1);
        2'b01:   inflight_q <= inflight_q - (PW+1)'(1);
        default: inflight_q <= inflight_q;
      endcase

      case ({alloc_hs, sub_hs})
        2'b10:   unsub <= unsub + (PW+1)'(1);
        2'b01:   unsub <= unsub - (PW+1)'(1);
        default: unsub <= unsub;
      endcase

      if (cqe_ok) begin
        cq_head       <= cq_head + PW'(1);
        if (cq_head == PW'(OUTSTANDING-1)) exp_phase <= ~exp_phase;
        done_cid_q    <= q.cqe_cid[PW-1:0];
        done_status_q <= q.cqe_status;
        done_vld_q    <= 1'b1;
      end else if (q.done_ready) begin
        done_vld_q    <= 1'b0;
      end

      if (cqe_bad | bad_resp) err_q <= 1'b1;

      // an update landing in the snapshot cycle keeps the flag so the newer pointer follows
      sq_db_pend <= sub_hs | (sq_db_pend & ~idle_take_sq);
      cq_db_pend <= cqe_ok | (cq_db_pend & ~idle_take_cq);

      case (state)
        ST_IDLE: begin
          if (cq_db_pend) begin
            awaddr_q <= NL_ADDR_WIDTH'(CQ_DB_ADDR);
            wdata_q  <= NL_DATA_WIDTH'(cq_head);
            aw_vld   <= 1'b1;
            w_vld    <= 1'b1;
            state    <= ST_ADDR;
          end else if (sq_db_pend) begin
            awaddr_q <= NL_ADDR_WIDTH'(SQ_DB_ADDR);
            wdata_q  <= NL_DATA_WIDTH'(sub_ptr);
            aw_vld   <= 1'b1;
            w_vld    <= 1'b1;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (q.nl_awready) aw_vld <= 1'b0;
          if (q.nl_wready)  w_vld  <= 1'b0;
          if (aw_done & w_done) state <= ST_RESP;
        end
        ST_RESP: begin
          if (q.nl_bvalid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
